student_tlul_host: RTL and testbench

STUDENT_TLUL_HOST -- requirements
Module: student_tlul_host

---
 rtl/student_tlul_host_pkg.sv | 69 ++++++
 rtl/student_tlul_host_timer.sv | 28 ++
 rtl/student_tlul_host.sv | 111 +++++++++++
 tb/tb_student_tlul_host.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/student_tlul_host_pkg.sv
// Shared types for the TL-UL host.
//   tlul_pkg              : minimal TL-UL channel structs and opcodes
//   student_tlul_host_pkg : host FSM states, command/response records,
//                           word-size constant and opcode selection helper
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

package student_tlul_host_pkg;

  localparam logic [1:0] TL_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  // Full-word writes use PutFullData; any partial byte mask needs PutPartialData.
  function automatic tlul_pkg::tl_a_op_e a_opcode(input cmd_t c);
    if (!c.we)           return tlul_pkg::Get;
    else if (c.be == 4'hF) return tlul_pkg::PutFullData;
    else                 return tlul_pkg::PutPartialData;
  endfunction

endpackage

// File: rtl/student_tlul_host_timer.sv
// Response-wait timer for the TL-UL host.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr          : hold count at zero (asserted whenever the host is not waiting)
//   en           : one wait cycle elapsed without a D beat
//   expired      : this enabled cycle is the LIMIT-th one
module student_tlul_host_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr)        cnt <= '0;
    else if (en && !expired) cnt <= cnt + 8'd1;
  end

  // Flags during the LIMIT-th empty wait cycle so the FSM leaves WAIT on that edge.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/student_tlul_host.sv
// Single-outstanding TL-UL host: turns a simple valid/ready command into one
// A-channel request, waits for the D beat, and returns a valid/ready response.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cmd_*               : command (we, byte addr, wdata, byte enables)
//   rsp_*               : response (rdata, error)
//   tl_o / tl_i         : TL-UL host-to-device / device-to-host channels
// Optional: STUDENT_TLUL_HOST_TIMEOUT_EN adds a response timeout of
// TIMEOUT_CYCLES wait cycles that completes the command with an error.
module student_tlul_host
  import student_tlul_host_pkg::*;
#(
  parameter int SOURCE_ID      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i
);

  localparam logic [7:0] SRC = 8'(SOURCE_ID);

  state_e state, state_n;
  cmd_t   cmd_q;
  rsp_t   rsp_q;
  logic   timeout;

`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
  student_tlul_host_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (state != WAIT),
    .en      ((state == WAIT) && !tl_i.d_valid),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // D-channel fields the host never needs, plus the dropped sub-word address bits.
  logic unused_in;
  assign unused_in = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                       cmd_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid_i)
        cmd_q <= '{we: cmd_we_i, addr: {cmd_addr_i[31:2], 2'b00},
                   wdata: cmd_wdata_i, be: cmd_be_i};
      if (state == WAIT) begin
        if (tl_i.d_valid)
          rsp_q <= '{rdata: cmd_q.we ? 32'h0 : tl_i.d_data,
                     error: tl_i.d_error | (tl_i.d_source != SRC)};
        else if (timeout)
          rsp_q <= '{rdata: 32'h0, error: 1'b1};
      end
    end
  end

  always_comb begin
    state_n     = state;
    cmd_ready_o = 1'b0;
    tl_o        = '0;
    unique case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_n = REQ;
      end
      REQ: begin
        tl_o.a_valid   = 1'b1;
        tl_o.a_opcode  = a_opcode(cmd_q);
        tl_o.a_size    = TL_SIZE_WORD;
        tl_o.a_source  = SRC;
        tl_o.a_address = cmd_q.addr;
        tl_o.a_mask    = cmd_q.we ? cmd_q.be : 4'hF;
        tl_o.a_data    = cmd_q.we ? cmd_q.wdata : 32'h0;
        if (tl_i.a_ready) state_n = WAIT;
      end
      WAIT: begin
        tl_o.d_ready = 1'b1;
        if (tl_i.d_valid || timeout) state_n = RSP;
      end
      RSP: begin
        if (rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rsp_valid_o = (state == RSP);
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_error_o = rsp_q.error;

endmodule

// File: tb/tb_student_tlul_host.sv
// Self-checking bench for student_tlul_host: directed vector table, random
// transactions against a rule-level model, plus reset and timeout sequences.
module tb_student_tlul_host;
  import tlul_pkg::*;

  localparam int SRC = 3;
  localparam int TO  = 10;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          a_dly, d_dly, r_dly;
    logic [31:0] d_data;
    logic        d_err;
    logic [7:0]  d_src;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [2:0]  op, param;
    logic [3:0]  mask;
    logic [31:0] addr, data, rdata;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        err;
    int          av, hs, turn;
    bit          stable, ok;
  } obs_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0] rsp_rdata;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int errors = 0, checks = 0;

  student_tlul_host #(.SOURCE_ID(SRC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rule-level reference: what the host must produce for a command and a D beat.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (!v.we)             r.e_op = 3'(Get);
    else if (v.be == 4'hF) r.e_op = 3'(PutFullData);
    else                   r.e_op = 3'(PutPartialData);
    r.e_mask  = v.we ? v.be : 4'hF;
    r.e_rdata = v.we ? 32'h0 : v.d_data;
    r.e_err   = v.d_err || (v.d_src != 8'(SRC));
    return r;
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, wdata,
                              input logic [3:0] be, input int ad, dd, rd,
                              input logic [31:0] ddata, input logic derr,
                              input logic [7:0] dsrc, input logic [2:0] eop,
                              input logic [3:0] emask, input logic [31:0] erd,
                              input logic eerr);
    return '{we, addr, wdata, be, ad, dd, rd, ddata, derr, dsrc, eop, emask, erd, eerr};
  endfunction

  task automatic run_txn(input vec_t v, output obs_t o);
    bit rdy = 0;
    o = '{op: 0, param: 0, mask: 0, addr: 0, data: 0, rdata: 0, size: 0, src: 0,
          err: 0, av: 0, hs: 0, turn: 0, stable: 1, ok: 0};
    cmd_valid = 1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_be = v.be;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    tick(); o.turn++;
    // Keep offering a different command while busy; it must be ignored.
    cmd_we = ~v.we; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);
    for (int n = 0; n < 64 && !rdy; n++) begin
      chk("busy_cmd_ready", 32'(cmd_ready), 0);
      if (tl_o.a_valid) begin
        o.av++;
        if (o.av == 1) begin
          o.op = 3'(tl_o.a_opcode); o.param = tl_o.a_param; o.mask = tl_o.a_mask;
          o.addr = tl_o.a_address; o.data = tl_o.a_data; o.size = tl_o.a_size;
          o.src = tl_o.a_source;
        end else if (o.op != 3'(tl_o.a_opcode) || o.mask != tl_o.a_mask ||
                     o.addr != tl_o.a_address || o.data != tl_o.a_data ||
                     o.src != tl_o.a_source || o.size != tl_o.a_size)
          o.stable = 0;
        rdy = (o.av > v.a_dly);
      end
      tl_i.a_ready = rdy;
      if (rdy) o.hs++;
      tick(); o.turn++;
    end
    tl_i.a_ready = 0;
    if (!rdy) begin
      chk("a_handshake_timeout", 0, 1);
      cmd_valid = 0; return;
    end
    chk("a_valid_after_hs", 32'(tl_o.a_valid), 0);
    for (int n = 0; n < v.d_dly; n++) begin
      chk("wait_d_ready", 32'(tl_o.d_ready), 1);
      chk("wait_rsp_valid", 32'(rsp_valid), 0);
      tick(); o.turn++;
    end
    chk("wait_d_ready", 32'(tl_o.d_ready), 1);
    tl_i.d_valid = 1; tl_i.d_data = v.d_data; tl_i.d_error = v.d_err; tl_i.d_source = v.d_src;
    tick(); o.turn++;
    tl_i.d_valid = 0; tl_i.d_data = $urandom; tl_i.d_error = 0; tl_i.d_source = 8'(SRC);
    cmd_valid = 0;
    chk("rsp_valid", 32'(rsp_valid), 1);
    o.rdata = rsp_rdata; o.err = rsp_error;
    for (int n = 0; n < v.r_dly; n++) begin
      tick(); o.turn++;
      chk("rsp_hold_valid", 32'(rsp_valid), 1);
      chk("rsp_hold_rdata", rsp_rdata, o.rdata);
      chk("rsp_hold_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1;
    tick(); o.turn++;
    rsp_ready = 0;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_cmd_ready", 32'(cmd_ready), 1);
    o.ok = 1;
  endtask

  task automatic cmp(input vec_t v, input obs_t o, input int idx);
    if (!o.ok) return;
    chk($sformatf("v%0d_opcode", idx), 32'(o.op), 32'(v.e_op));
    chk($sformatf("v%0d_mask", idx), 32'(o.mask), 32'(v.e_mask));
    chk($sformatf("v%0d_addr", idx), o.addr, v.addr & ~32'h3);
    chk($sformatf("v%0d_adata", idx), o.data, v.we ? v.wdata : 32'h0);
    chk($sformatf("v%0d_size", idx), 32'(o.size), 2);
    chk($sformatf("v%0d_source", idx), 32'(o.src), SRC);
    chk($sformatf("v%0d_param", idx), 32'(o.param), 0);
    chk($sformatf("v%0d_rdata", idx), o.rdata, v.e_rdata);
    chk($sformatf("v%0d_error", idx), 32'(o.err), 32'(v.e_err));
    chk($sformatf("v%0d_avalid_cycles", idx), o.av, v.a_dly + 1);
    chk($sformatf("v%0d_a_handshakes", idx), o.hs, 1);
    chk($sformatf("v%0d_a_stable", idx), 32'(o.stable), 1);
    chk($sformatf("v%0d_turnaround", idx), o.turn, 4 + v.a_dly + v.d_dly + v.r_dly);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    obs_t o;
    int   k;
    tl_i = '0; tl_i.d_source = 8'(SRC);

    tbl[0] = mk(1, 32'h4,  32'h2,        4'hF, 0, 0, 0, 32'h0,        0, 8'(SRC),
                3'(PutFullData),    4'hF, 32'h0,        0);
    tbl[1] = mk(0, 32'h0,  32'h0,        4'hF, 0, 0, 0, 32'h0000FFFF, 0, 8'(SRC),
                3'(Get),            4'hF, 32'h0000FFFF, 0);
    tbl[2] = mk(1, 32'h13, 32'hA5A5A5A5, 4'h1, 5, 0, 0, 32'hDEADBEEF, 0, 8'(SRC),
                3'(PutPartialData), 4'h1, 32'h0,        0);
    tbl[3] = mk(0, 32'h8,  32'h0,        4'hF, 0, 1, 0, 32'h1234,     1, 8'(SRC),
                3'(Get),            4'hF, 32'h1234,     1);
    tbl[4] = mk(0, 32'hC,  32'h0,        4'hF, 0, 0, 1, 32'h5678,     0, 8'(SRC + 1),
                3'(Get),            4'hF, 32'h5678,     1);
    tbl[5] = mk(0, 32'h22, 32'h0,        4'h3, 2, 3, 2, 32'hCAFEF00D, 0, 8'(SRC),
                3'(Get),            4'hF, 32'hCAFEF00D, 0);

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", 32'(rsp_error), 0);
    chk("rst_a_valid", 32'(tl_o.a_valid), 0);
    chk("rst_d_ready", 32'(tl_o.d_ready), 0);
    rst = 0;
    tick();

    foreach (tbl[i]) begin
      run_txn(tbl[i], o);
      cmp(tbl[i], o, i);
    end

    // Reset while in WAIT abandons the transaction; a late D beat is ignored.
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h20; cmd_be = 4'hF;
    tick(); cmd_valid = 0;
    chk("rw_a_valid", 32'(tl_o.a_valid), 1);
    tl_i.a_ready = 1; tick(); tl_i.a_ready = 0;
    chk("rw_in_wait", 32'(tl_o.d_ready), 1);
    rst = 1; tick(); rst = 0;
    chk("rw_cmd_ready", 32'(cmd_ready), 1);
    chk("rw_rsp_valid", 32'(rsp_valid), 0);
    chk("rw_rsp_rdata", rsp_rdata, 0);
    chk("rw_rsp_error", 32'(rsp_error), 0);
    chk("rw_a_valid", 32'(tl_o.a_valid), 0);
    chk("rw_d_ready", 32'(tl_o.d_ready), 0);
    tl_i.d_valid = 1; tl_i.d_data = 32'hBAD0BAD0; tl_i.d_error = 1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stale_rsp_valid", 32'(rsp_valid), 0);
      chk("stale_cmd_ready", 32'(cmd_ready), 1);
      chk("stale_d_ready", 32'(tl_o.d_ready), 0);
    end
    tl_i.d_valid = 0; tl_i.d_error = 0;

`ifdef STUDENT_TLUL_HOST_TIMEOUT_EN
    // No D beat: response must appear exactly TO wait cycles after the A handshake.
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h40; cmd_be = 4'hF;
    tick(); cmd_valid = 0;
    tl_i.a_ready = 1; tick(); tl_i.a_ready = 0;
    k = 0;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      tick();
      if (rsp_valid) k = n;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_error", 32'(rsp_error), 1);
    chk("timeout_rdata", rsp_rdata, 0);
    rsp_ready = 1; tick(); rsp_ready = 0;
    chk("timeout_idle", 32'(cmd_ready), 1);
`else
    // Without the timeout, a D beat far beyond any counter range still completes.
    v = model(mk(0, 32'h80, 0, 4'hF, 0, 300, 0, 32'h0BADCAFE, 0, 8'(SRC), 0, 0, 0, 0));
    run_txn(v, o);
    cmp(v, o, 100);
`endif

    for (int i = 0; i < 20; i++) begin
      v.we = 1'($urandom); v.addr = $urandom; v.wdata = $urandom;
      v.be = 4'($urandom_range(1, 15));
      v.a_dly = $urandom_range(0, 3); v.d_dly = $urandom_range(0, 3);
      v.r_dly = $urandom_range(0, 2);
      v.d_data = $urandom; v.d_err = ($urandom_range(0, 7) == 0);
      v.d_src = ($urandom_range(0, 7) == 0) ? 8'(SRC + 1) : 8'(SRC);
      v = model(v);
      run_txn(v, o);
      cmp(v, o, 200 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
